and_gate: RTL and testbench

AND_GATE -- requirements
Module: and_gate

---
 rtl/and_gate_pkg.sv | 13 +
 rtl/and_popcount.sv | 20 ++
 rtl/and_gate.sv | 105 ++++++++++
 tb/tb_and_gate.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/and_gate_pkg.sv
// Shared constants and helpers for the and_gate block.
// Holds the default operand width and statistics counter width.
package and_gate_pkg;

   localparam int DEF_WIDTH = 1;
   localparam int DEF_CNT_W = 16;

   // Bits needed to hold a popcount of a w-bit vector (0..w inclusive).
   function automatic int cnt_bits(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/and_popcount.sv
// Combinational population count of a WIDTH-bit vector.
// Result width is cnt_bits(WIDTH) so the all-ones case fits.
module and_popcount
   import and_gate_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   localparam int CW = cnt_bits(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [CW-1:0]    cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt = cnt + CW'(vec[i]);
      end
   end

endmodule

// File: rtl/and_gate.sv
// Bitwise AND with a combinational result and a registered result plus flags.
// Optional accepted-nonzero counter stat_cnt is built when AND_GATE_STATS_EN is defined.
module and_gate
   import and_gate_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W,
   localparam int CW = cnt_bits(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] entrada1,
   input  logic [WIDTH-1:0] entrada2,
   input  logic             in_valid,
   output logic [WIDTH-1:0] resultado,
   output logic [WIDTH-1:0] resultado_q,
   output logic             out_valid,
   output logic             all_ones,
   output logic             any_one,
   output logic [CW-1:0]    ones_cnt
`ifdef AND_GATE_STATS_EN
   ,
   output logic [CNT_W-1:0] stat_cnt
`endif
);

   logic [WIDTH-1:0] and_v;
   logic [CW-1:0]    pop_v;

   logic [WIDTH-1:0] resultado_d;
   logic             out_valid_d, out_valid_q;
   logic             all_ones_d, all_ones_q;
   logic             any_one_d, any_one_q;
   logic [CW-1:0]    ones_cnt_d, ones_cnt_q;

   assign and_v     = entrada1 & entrada2;
   assign resultado = and_v;

   // Flags are derived from the incoming AND so they land with resultado_q.
   and_popcount #(
      .WIDTH (WIDTH)
   ) u_pop (
      .vec (and_v),
      .cnt (pop_v)
   );

   always_comb begin
      resultado_d = resultado_q;
      all_ones_d  = all_ones_q;
      any_one_d   = any_one_q;
      ones_cnt_d  = ones_cnt_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         resultado_d = and_v;
         all_ones_d  = &and_v;
         any_one_d   = |and_v;
         ones_cnt_d  = pop_v;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resultado_q <= '0;
         out_valid_q <= 1'b0;
         all_ones_q  <= 1'b0;
         any_one_q   <= 1'b0;
         ones_cnt_q  <= '0;
      end else begin
         resultado_q <= resultado_d;
         out_valid_q <= out_valid_d;
         all_ones_q  <= all_ones_d;
         any_one_q   <= any_one_d;
         ones_cnt_q  <= ones_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign all_ones  = all_ones_q;
   assign any_one   = any_one_q;
   assign ones_cnt  = ones_cnt_q;

`ifdef AND_GATE_STATS_EN
   logic [CNT_W-1:0] stat_cnt_d, stat_cnt_q;

   // Saturating count of accepted operations with a nonzero result.
   always_comb begin
      stat_cnt_d = stat_cnt_q;
      if (in_valid && (|and_v) && (stat_cnt_q != '1)) begin
         stat_cnt_d = stat_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_cnt_q <= '0;
      end else begin
         stat_cnt_q <= stat_cnt_d;
      end
   end

   assign stat_cnt = stat_cnt_q;
`else
`endif

endmodule

// File: tb/tb_and_gate.sv
// Directed and randomized checks of and_gate at WIDTH=1 and WIDTH=8.
// The WIDTH=8 instance uses CNT_W=2 so stat_cnt saturation is reachable.
module tb_and_gate;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] a8, b8;
   logic       a1, b1;

   logic [7:0] res8, resq8;
   logic       ov8, all8, any8;
   logic [3:0] cnt8;
   logic       res1, resq1;
   logic       ov1, all1, any1;
   logic [0:0] cnt1;
`ifdef AND_GATE_STATS_EN
   logic [1:0] stat8;
   logic [15:0] stat1;
`endif

   int vectors;
   int miscompares;

   logic [7:0] m_q8;
   logic       m_ov8;
   logic       m_q1;
   logic       m_ov1;
   int         m_nz;

   and_gate #(
      .WIDTH (8),
      .CNT_W (2)
   ) u8 (
      .clk         (clk),
      .rst_n       (rst_n),
      .entrada1    (a8),
      .entrada2    (b8),
      .in_valid    (in_valid),
      .resultado   (res8),
      .resultado_q (resq8),
      .out_valid   (ov8),
      .all_ones    (all8),
      .any_one     (any8),
      .ones_cnt    (cnt8)
`ifdef AND_GATE_STATS_EN
      ,
      .stat_cnt    (stat8)
`endif
   );

   and_gate #(
      .WIDTH (1)
   ) u1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .entrada1    (a1),
      .entrada2    (b1),
      .in_valid    (in_valid),
      .resultado   (res1),
      .resultado_q (resq1),
      .out_valid   (ov1),
      .all_ones    (all1),
      .any_one     (any1),
      .ones_cnt    (cnt1)
`ifdef AND_GATE_STATS_EN
      ,
      .stat_cnt    (stat1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [7:0] e8;
      e8 = a8 & b8;
      check("res8", 32'(res8), 32'(e8));
      check("resq8", 32'(resq8), 32'(m_q8));
      check("ov8", 32'(ov8), 32'(m_ov8));
      check("all8", 32'(all8), 32'(m_q8 == 8'hFF));
      check("any8", 32'(any8), 32'(m_q8 != 8'h00));
      check("cnt8", 32'(cnt8), 32'($countones(m_q8)));
      check("res1", 32'(res1), 32'(a1 & b1));
      check("resq1", 32'(resq1), 32'(m_q1));
      check("ov1", 32'(ov1), 32'(m_ov1));
      check("all1", 32'(all1), 32'(m_q1));
      check("any1", 32'(any1), 32'(m_q1));
      check("cnt1", 32'(cnt1), 32'(m_q1));
`ifdef AND_GATE_STATS_EN
      check("stat8", 32'(stat8), 32'((m_nz > 3) ? 3 : m_nz));
`endif
   endtask

   // Advance the reference by one edge, then compare after the edge.
   task automatic step();
      if (!rst_n) begin
         m_q8  = '0;
         m_ov8 = 1'b0;
         m_q1  = 1'b0;
         m_ov1 = 1'b0;
         m_nz  = 0;
      end else begin
         m_ov8 = in_valid;
         m_ov1 = in_valid;
         if (in_valid) begin
            m_q8 = a8 & b8;
            m_q1 = a1 & b1;
            if (m_q8 != 0) m_nz++;
         end
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      m_nz        = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      a8          = '0;
      b8          = '0;
      a1          = 1'b0;
      b1          = 1'b0;

      // Combinational truth table, no clock edge involved.
      for (int i = 0; i < 4; i++) begin
         a1 = i[1];
         b1 = i[0];
         #1;
         check("tt1", 32'(res1), 32'(i == 3));
      end

      // Reset wins over in_valid; combinational path still live.
      rst_n    = 1'b0;
      in_valid = 1'b1;
      a8 = 8'hF0; b8 = 8'h3C; a1 = 1'b1; b1 = 1'b1;
      step();
      check("rst_res8", 32'(res8), 32'h30);

      rst_n = 1'b1;
      step();
      check("f0_3c_q", 32'(resq8), 32'h30);
      check("f0_3c_cnt", 32'(cnt8), 32'd2);

      a8 = 8'hFF; b8 = 8'hFF;
      step();
      check("ff_all", 32'(all8), 32'd1);
      check("ff_cnt", 32'(cnt8), 32'd8);

      in_valid = 1'b0;
      a8 = 8'h12; b8 = 8'h36; a1 = 1'b0;
      step();
      check("hold_q", 32'(resq8), 32'hFF);
      check("hold_ov", 32'(ov8), 32'd0);

      // Three more nonzero accepts, one zero accept: count saturates.
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a8 = 8'h81 << i; b8 = 8'hFF;
         step();
      end
      a8 = 8'hAA; b8 = 8'h55;
      step();
`ifdef AND_GATE_STATS_EN
      check("stat_sat", 32'(stat8), 32'd3);
`endif

      // Randomized traffic with occasional resets and idle cycles.
      for (int i = 0; i < 200; i++) begin
         rst_n    = ($urandom_range(0, 15) != 0);
         in_valid = ($urandom_range(0, 3) != 0);
         a8 = 8'($urandom);
         b8 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
         a1 = 1'($urandom);
         b1 = 1'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
